// File: rtl/bomba_duplex_ctrl.sv
// Duplex sump-pump scheduler: lead/lag alternation, anti-short-cycle timing,
// and latched sensor/timeout faults driven from a synchronized 3-bit level bus.
module bomba_duplex_ctrl #(
  parameter int TW      = 16,
  parameter int MIN_ON  = 16,
  parameter int MIN_OFF = 16,
  parameter int MAX_RUN = 1024
) (
  input  logic       ck,
  input  logic       rst_i,
  input  logic [2:0] sensores_i,
  input  logic       ack_i,
  output logic [1:0] bomba_o,
  output logic       alarma_o,
  output logic [1:0] fault_o,
  output logic       lead_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_LEAD = 3'd1,
    RUN_BOTH = 3'd2,
    REST     = 3'd3,
    FAULT    = 3'd4
  } state_t;

  localparam logic [TW-1:0] MIN_ON_T   = TW'(MIN_ON);
  localparam logic [TW-1:0] MIN_OFF_M1 = TW'(MIN_OFF - 1);
  localparam logic [TW-1:0] MAX_RUN_M1 = TW'(MAX_RUN - 1);
  localparam logic [TW-1:0] TMR_SAT    = '1;

  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_SENS = 2'b01;
  localparam logic [1:0] F_TOUT = 2'b10;

  logic [2:0]    sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          lead_q, lead_d;
  logic [1:0]    code_q, code_d;
  logic [1:0]    bomba_q;
  logic          alarma_q;
  logic [1:0]    fault_q;

  logic s0, s1, s2, inv;

  assign s0  = sync2_q[0];
  assign s1  = sync2_q[1];
  assign s2  = sync2_q[2];
  assign inv = (s2 & ~s1) | (s1 & ~s0);

  // Fault checks come first so an invalid level pattern or timeout always wins
  // over a stop or an escalation in the same cycle.
  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == TMR_SAT) ? timer_q : timer_q + 1'b1;
    lead_d  = lead_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (inv) begin
          state_d = FAULT;
          code_d  = F_SENS;
        end else if (s1) begin
          state_d = RUN_LEAD;
          timer_d = '0;
        end
      end
      RUN_LEAD, RUN_BOTH: begin
        if (inv) begin
          state_d = FAULT;
          code_d  = F_SENS;
        end else if (timer_q == MAX_RUN_M1) begin
          state_d = FAULT;
          code_d  = F_TOUT;
        end else if (!s0 && timer_q >= MIN_ON_T) begin
          state_d = REST;
          timer_d = '0;
          lead_d  = ~lead_q;
        end else if (state_q == RUN_LEAD && s2) begin
          state_d = RUN_BOTH;
        end else if (state_q == RUN_BOTH && !s1) begin
          // lag drops out mid-cycle; run time keeps accumulating for the lead
          state_d = RUN_LEAD;
        end
      end
      REST: begin
        if (inv) begin
          state_d = FAULT;
          code_d  = F_SENS;
        end else if (timer_q == MIN_OFF_M1) begin
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (ack_i && !inv) begin
          state_d = REST;
          timer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers follow the state one cycle later.
  always_ff @(posedge ck or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= IDLE;
      timer_q  <= '0;
      lead_q   <= 1'b0;
      code_q   <= F_NONE;
      bomba_q  <= 2'b00;
      alarma_q <= 1'b0;
      fault_q  <= F_NONE;
    end else begin
      sync1_q <= sensores_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      timer_q <= timer_d;
      lead_q  <= lead_d;
      code_q  <= code_d;
      case (state_q)
        RUN_LEAD: bomba_q <= lead_q ? 2'b10 : 2'b01;
        RUN_BOTH: bomba_q <= 2'b11;
        default:  bomba_q <= 2'b00;
      endcase
      alarma_q <= (state_q == FAULT);
      fault_q  <= (state_q == FAULT) ? code_q : F_NONE;
    end
  end

  assign bomba_o  = bomba_q;
  assign alarma_o = alarma_q;
  assign fault_o  = fault_q;
  assign lead_o   = lead_q;

endmodule

// File: tb/tb_bomba_duplex_ctrl.sv
// Directed vector bench for bomba_duplex_ctrl: alternation, escalation,
// min-on/min-off timing, faults with ack, timeout and async reset.
module tb_bomba_duplex_ctrl;

  logic       ck;
  logic       rst_i;
  logic [2:0] sensores_i;
  logic       ack_i;
  logic [1:0] bomba_o;
  logic       alarma_o;
  logic [1:0] fault_o;
  logic       lead_o;

  bomba_duplex_ctrl #(.TW(16), .MIN_ON(16), .MIN_OFF(16), .MAX_RUN(64)) dut (
    .ck         (ck),
    .rst_i      (rst_i),
    .sensores_i (sensores_i),
    .ack_i      (ack_i),
    .bomba_o    (bomba_o),
    .alarma_o   (alarma_o),
    .fault_o    (fault_o),
    .lead_o     (lead_o)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic [2:0] s;
    logic       ack;
    int         n;
    logic [1:0] bomba;
    logic       alarma;
    logic [1:0] fault;
    logic       lead;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];
  int   nvec;
  int   nerr;

  task automatic check(input string name, input logic [1:0] eb, input logic ea,
                       input logic [1:0] ef, input logic el);
    nvec++;
    if (bomba_o !== eb || alarma_o !== ea || fault_o !== ef || lead_o !== el) begin
      nerr++;
      $display("FAIL %s: got bomba=%b alarma=%b fault=%b lead=%b, want bomba=%b alarma=%b fault=%b lead=%b",
               name, bomba_o, alarma_o, fault_o, lead_o, eb, ea, ef, el);
    end
  endtask

  initial begin
    bit seen;
    nvec = 0;
    nerr = 0;
    // edge counts below are relative to the reference edge E0 after reset release
    vec[0]  = '{3'b011, 1'b0,  3, 2'b00, 1'b0, 2'b00, 1'b0}; // E3 state just entered RUN_LEAD
    vec[1]  = '{3'b011, 1'b0,  1, 2'b01, 1'b0, 2'b00, 1'b0}; // E4 pump 0 on
    vec[2]  = '{3'b000, 1'b0, 15, 2'b01, 1'b0, 2'b00, 1'b0}; // E19 low level, still inside min-on
    vec[3]  = '{3'b000, 1'b0,  1, 2'b01, 1'b0, 2'b00, 1'b1}; // E20 REST, lead toggled, output lags
    vec[4]  = '{3'b000, 1'b0,  1, 2'b00, 1'b0, 2'b00, 1'b1}; // E21 pumps off
    vec[5]  = '{3'b011, 1'b0, 16, 2'b00, 1'b0, 2'b00, 1'b1}; // E37 no restart during REST
    vec[6]  = '{3'b011, 1'b0,  1, 2'b10, 1'b0, 2'b00, 1'b1}; // E38 pump 1 leads
    vec[7]  = '{3'b111, 1'b0,  3, 2'b10, 1'b0, 2'b00, 1'b1}; // E41 RUN_BOTH entered
    vec[8]  = '{3'b111, 1'b0,  1, 2'b11, 1'b0, 2'b00, 1'b1}; // E42 both on
    vec[9]  = '{3'b001, 1'b0,  3, 2'b11, 1'b0, 2'b00, 1'b1}; // E45 back to RUN_LEAD
    vec[10] = '{3'b001, 1'b0,  1, 2'b10, 1'b0, 2'b00, 1'b1}; // E46 lag dropped
    vec[11] = '{3'b001, 1'b0, 20, 2'b10, 1'b0, 2'b00, 1'b1}; // E66 lead keeps running
    vec[12] = '{3'b000, 1'b0,  3, 2'b10, 1'b0, 2'b00, 1'b0}; // E69 REST, lead back to 0
    vec[13] = '{3'b000, 1'b0,  1, 2'b00, 1'b0, 2'b00, 1'b0}; // E70 pumps off
    vec[14] = '{3'b101, 1'b0,  3, 2'b00, 1'b0, 2'b00, 1'b0}; // E73 FAULT entered
    vec[15] = '{3'b101, 1'b0,  1, 2'b00, 1'b1, 2'b01, 1'b0}; // E74 sensor fault shown
    vec[16] = '{3'b101, 1'b1,  4, 2'b00, 1'b1, 2'b01, 1'b0}; // E78 ack ignored while invalid
    vec[17] = '{3'b000, 1'b1,  3, 2'b00, 1'b1, 2'b01, 1'b0}; // E81 REST entered
    vec[18] = '{3'b000, 1'b1,  1, 2'b00, 1'b0, 2'b00, 1'b0}; // E82 fault cleared
    vec[19] = '{3'b011, 1'b0, 17, 2'b01, 1'b0, 2'b00, 1'b0}; // E99 running after REST
    vec[20] = '{3'b011, 1'b0, 63, 2'b01, 1'b0, 2'b00, 1'b0}; // E162 last cycle before timeout
    vec[21] = '{3'b011, 1'b0,  1, 2'b00, 1'b1, 2'b10, 1'b0}; // E163 timeout fault

    rst_i      = 1'b1;
    sensores_i = 3'b000;
    ack_i      = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    check("reset", 2'b00, 1'b0, 2'b00, 1'b0);
    @(negedge ck);
    rst_i = 1'b0;
    @(posedge ck);
    #1;

    for (int i = 0; i < NV; i++) begin
      sensores_i = vec[i].s;
      ack_i      = vec[i].ack;
      repeat (vec[i].n) @(posedge ck);
      #1;
      check($sformatf("vec%0d", i), vec[i].bomba, vec[i].alarma, vec[i].fault, vec[i].lead);
    end

    // Ack out of timeout fault, climb to RUN_BOTH, then hit reset between edges.
    sensores_i = 3'b111;
    ack_i      = 1'b1;
    seen       = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      @(posedge ck);
      #1;
      if (bomba_o == 2'b11) seen = 1'b1;
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL run_both_wait: bomba=%b never reached 11 within 80 cycles", bomba_o);
    end
    ack_i = 1'b0;
    @(posedge ck);
    #3;
    rst_i = 1'b1;
    #1;
    check("async_reset", 2'b00, 1'b0, 2'b00, 1'b0);
    @(posedge ck);
    #1;
    check("reset_hold", 2'b00, 1'b0, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
